stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 111 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaled one-second tick, mm:ss counter,
// run/pause/overflow FSM and lap capture register.
module stopwatch_ctrl #(
  parameter logic [25:0] DIVISOR = 26'd50000000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       zero,
  output logic [1:0] state,
  output logic       tick,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] lap_sec,
  output logic [5:0] lap_min,
  output logic       lap_valid,
  output logic       overflow
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] OVF   = 2'b11;

  logic [25:0] cnt;
  logic        term;
  logic        last;
  logic        lap_ok;

  assign term   = (state == RUN) && (cnt == DIVISOR - 26'd1);
  assign last   = (sec == 6'd59) && (min == 6'd59);
  assign lap_ok = lap && !start_stop &&
                  ((state == RUN) || (state == PAUSE));

  assign overflow = (state == OVF);

  // Mode FSM; a terminal count at 59:59 wins over a same-cycle start_stop
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else if (zero) begin
      state <= IDLE;
    end else if (term && last) begin
      state <= OVF;
    end else if (start_stop) begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     state <= PAUSE;
        PAUSE:   state <= RUN;
        default: state <= state;
      endcase
    end
  end

  // Prescaler runs only in RUN and keeps its phase across a pause
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= term ? '0 : cnt + 26'd1;
    end
  end

  // One-cycle tick registered on the wrap edge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tick <= 1'b0;
    end else begin
      tick <= term && !zero;
    end
  end

  // Seconds/minutes counter, frozen at 59:59 on overflow
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sec <= '0;
      min <= '0;
    end else if (zero) begin
      sec <= '0;
      min <= '0;
    end else if (term && !last) begin
      if (sec == 6'd59) begin
        sec <= '0;
        min <= min + 6'd1;
      end else begin
        sec <= sec + 6'd1;
      end
    end
  end

  // Lap capture samples the pre-increment time
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      lap_sec   <= '0;
      lap_min   <= '0;
      lap_valid <= 1'b0;
    end else if (zero) begin
      lap_sec   <= '0;
      lap_min   <= '0;
      lap_valid <= 1'b0;
    end else if (lap_ok) begin
      lap_sec   <= sec;
      lap_min   <= min;
      lap_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DIVISOR=4:
// vector table, directed corner sequences and random commands vs a model.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       zero = 1'b0;
  logic [1:0] state;
  logic       tick;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;
  logic       lap_valid;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // model: mode code, phase within current second, elapsed seconds
  int m_st, m_ph, m_t, m_lt, m_lv, m_tick;

  stopwatch_ctrl #(.DIVISOR(26'd4)) dut (
    .clk(clk),
    .clear(clear),
    .start_stop(start_stop),
    .lap(lap),
    .zero(zero),
    .state(state),
    .tick(tick),
    .sec(sec),
    .min(min),
    .lap_sec(lap_sec),
    .lap_min(lap_min),
    .lap_valid(lap_valid),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ss;
    bit lp;
    bit zr;
    int st;
    int tk;
    int s;
    int ls;
    int lv;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_ph = 0; m_t = 0;
    m_lt = 0; m_lv = 0; m_tick = 0;
  endtask

  task automatic m_step(input bit ss, input bit lp, input bit zr);
    int  ost;
    bit  wrap;
    ost  = m_st;
    wrap = (ost == 1) && (m_ph == D - 1);
    m_tick = 0;
    if (zr) begin
      m_reset();
    end else begin
      if (lp && !ss && (ost == 1 || ost == 2)) begin
        m_lt = m_t;
        m_lv = 1;
      end
      if (ost == 1) m_ph = wrap ? 0 : m_ph + 1;
      if (wrap) m_tick = 1;
      if (wrap && m_t == 3599) begin
        m_st = 3;
      end else begin
        if (wrap) m_t++;
        if (ss) begin
          if (ost == 0) m_st = 1;
          else if (ost == 1) m_st = 2;
          else if (ost == 2) m_st = 1;
        end
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".state"}, int'(state), m_st);
    chk({tag, ".tick"}, int'(tick), m_tick);
    chk({tag, ".sec"}, int'(sec), m_t % 60);
    chk({tag, ".min"}, int'(min), m_t / 60);
    chk({tag, ".lap_sec"}, int'(lap_sec), m_lt % 60);
    chk({tag, ".lap_min"}, int'(lap_min), m_lt / 60);
    chk({tag, ".lap_valid"}, int'(lap_valid), m_lv);
    chk({tag, ".overflow"}, int'(overflow), (m_st == 3) ? 1 : 0);
  endtask

  task automatic cyc(input bit ss, input bit lp, input bit zr);
    start_stop = ss;
    lap = lp;
    zero = zr;
    @(posedge clk);
    m_step(ss, lp, zr);
    #1;
    start_stop = 1'b0;
    lap = 1'b0;
    zero = 1'b0;
  endtask

  initial begin
    int n;

    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 0, 1, 1, 1};
    tbl[8]  = '{1, 0, 0, 2, 0, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 2, 0, 1, 1, 1};
    tbl[10] = '{1, 0, 0, 1, 0, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 1, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 0, 1, 1, 2, 1, 1};
    tbl[13] = '{1, 1, 1, 0, 0, 0, 0, 0};

    // reset state
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.state", int'(state), 0);
    chk("rst.tick", int'(tick), 0);
    chk("rst.sec", int'(sec), 0);
    chk("rst.min", int'(min), 0);
    chk("rst.lap_valid", int'(lap_valid), 0);
    chk("rst.overflow", int'(overflow), 0);
    clear = 1'b0;

    // vector table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].ss, tbl[i].lp, tbl[i].zr);
      chk($sformatf("vec%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("vec%0d.tick", i), int'(tick), tbl[i].tk);
      chk($sformatf("vec%0d.sec", i), int'(sec), tbl[i].s);
      chk($sformatf("vec%0d.min", i), int'(min), 0);
      chk($sformatf("vec%0d.lap_sec", i), int'(lap_sec), tbl[i].ls);
      chk($sformatf("vec%0d.lap_valid", i), int'(lap_valid), tbl[i].lv);
      cmp_all($sformatf("vec%0d.model", i));
    end

    // seconds roll into minutes on one edge
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    n = 0;
    while (m_t < 60 && n < 400) begin
      cyc(0, 0, 0);
      cmp_all("roll");
      n++;
    end
    chk("roll.timeout", (n < 400) ? 1 : 0, 1);
    chk("roll.sec", int'(sec), 0);
    chk("roll.min", int'(min), 1);
    chk("roll.tick", int'(tick), 1);

    // pause mid-second, resume completes remaining phase
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("pause.state", int'(state), 2);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0);
      chk("pause.tick", int'(tick), 0);
      chk("pause.hold", int'(state), 2);
    end
    cyc(1, 0, 0);
    chk("resume.state", int'(state), 1);
    cyc(0, 0, 0);
    chk("resume.tick1", int'(tick), 0);
    cyc(0, 0, 0);
    chk("resume.tick2", int'(tick), 1);
    chk("resume.sec", int'(sec), 1);

    // run to overflow
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    n = 0;
    while (m_st != 3 && n < 16000) begin
      cyc(0, 0, 0);
      cmp_all("ovf_run");
      n++;
    end
    chk("ovf.timeout", (n < 16000) ? 1 : 0, 1);
    chk("ovf.state", int'(state), 3);
    chk("ovf.flag", int'(overflow), 1);
    chk("ovf.sec", int'(sec), 59);
    chk("ovf.min", int'(min), 59);
    cyc(1, 0, 0);
    chk("ovf.ss_state", int'(state), 3);
    repeat (4) begin
      cyc(0, 0, 0);
      chk("ovf.frozen", int'(sec), 59);
      chk("ovf.notick", int'(tick), 0);
    end
    cyc(0, 0, 1);
    chk("ovfz.state", int'(state), 0);
    chk("ovfz.sec", int'(sec), 0);
    chk("ovfz.min", int'(min), 0);
    chk("ovfz.flag", int'(overflow), 0);

    // lap coincident with tick
    cyc(1, 0, 0);
    n = 0;
    while (!(m_t == 5 && m_ph == D - 1) && n < 100) begin
      cyc(0, 0, 0);
      n++;
    end
    chk("laptick.timeout", (n < 100) ? 1 : 0, 1);
    cyc(0, 1, 0);
    chk("laptick.lap_sec", int'(lap_sec), 5);
    chk("laptick.sec", int'(sec), 6);
    chk("laptick.valid", int'(lap_valid), 1);
    chk("laptick.tick", int'(tick), 1);
    cyc(1, 1, 1);
    chk("allcmd.state", int'(state), 0);
    chk("allcmd.sec", int'(sec), 0);
    chk("allcmd.lap_sec", int'(lap_sec), 0);
    chk("allcmd.valid", int'(lap_valid), 0);

    // async clear mid-run at prescaler phase 2
    cyc(1, 0, 0);
    n = 0;
    while (!(m_t == 1 && m_ph == 1) && n < 100) begin
      cyc(0, 0, 0);
      n++;
    end
    cyc(0, 1, 0);
    chk("clr.pre_ph", m_ph, 2);
    cmp_all("clr.pre");
    clear = 1'b1;
    m_reset();
    #1;
    chk("clr.state", int'(state), 0);
    chk("clr.tick", int'(tick), 0);
    chk("clr.sec", int'(sec), 0);
    chk("clr.lap_sec", int'(lap_sec), 0);
    chk("clr.valid", int'(lap_valid), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("clr.held_tick", int'(tick), 0);
      chk("clr.held_state", int'(state), 0);
    end
    clear = 1'b0;
    repeat (6) begin
      cyc(0, 0, 0);
      cmp_all("clr.idle");
    end
    cyc(1, 0, 0);
    chk("clr.restart", int'(state), 1);

    // random commands against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 16) == 0, ($urandom % 8) == 0,
          ($urandom % 300) == 0);
      cmp_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
